// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the RAM sequencer slice.
// Holds the bus word type, the RAM handshake state seen by the core,
// the default access latency and the sequencer's internal FSM encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Handshake state reported to the requester every cycle.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam int RAM_LAT_DEFAULT = 2;

    // Sequencer FSM: waiting for a request, or counting down a latched one.
    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } seq_state_t;

endpackage

// File: rtl/ram_array.sv
// Word-addressed backing store: one synchronous write port, one async read port.
// Latency: write lands at the clock edge; read data is combinational from raddr.
// Backpressure: none; contents are deliberately not reset.
// Ports: CLK clock, we/waddr/wdata write port, raddr/rdata read port.
module ram_array
    import cpu_types_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  word_t         wdata,
    input  logic [AW-1:0] raddr,
    output word_t         rdata
);

    word_t mem [0:(1<<AW)-1];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ram_sequencer.sv
// Latency-emulating RAM front end: latches a held request and grants ACCESS after LAT cycles.
// Latency: a request stable from cycle t sees ACCESS in cycle t+LAT for one cycle.
// Backpressure: requester holds ramREN/ramWEN while ramstate is BUSY; any change restarts the count.
// Ports: CLK, nRST (async active-low), ramREN/ramWEN/ramaddr/ramstore request,
//        ramload read data, ramstate handshake. Optional macro RAM_ALIGN_CHECK_EN
//        makes a request with ramaddr[1:0] != 0 an ERROR.
module ram_sequencer
    import cpu_types_pkg::*;
#(
    parameter int LAT = RAM_LAT_DEFAULT,
    parameter int AW  = 14
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      ramREN,
    input  logic      ramWEN,
    input  word_t     ramaddr,
    input  word_t     ramstore,
    output word_t     ramload,
    output ramstate_t ramstate
);

    localparam int            CW     = $clog2(LAT + 1);
    localparam logic [CW-1:0] RELOAD = CW'(LAT - 1);

    seq_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          lat_wr, lat_wr_n;
    word_t         lat_addr, lat_addr_n;
    word_t         lat_data, lat_data_n;

    logic  req, invalid, hi_bad, align_bad;
    logic  same_op, same_addr, same_data, match, cnt_zero, access;
    logic  arr_we;
    word_t arr_rdata;

    assign req    = ramREN ^ ramWEN;
    // Addresses beyond the backing store are rejected even without a request.
    assign hi_bad = |ramaddr[31:AW+2];

`ifdef RAM_ALIGN_CHECK_EN
    assign align_bad = req & (|ramaddr[1:0]);
    assign same_addr = (ramaddr == lat_addr);
`else
    assign align_bad = 1'b0;
    assign same_addr = (ramaddr[31:2] == lat_addr[31:2]);
    logic unused_lsb;
    assign unused_lsb = ^{ramaddr[1:0], lat_addr[1:0]};
`endif

    assign invalid   = (ramREN & ramWEN) | hi_bad | align_bad;
    assign same_op   = (ramWEN == lat_wr);
    // Store data only matters for writes; a read ignores ramstore entirely.
    assign same_data = ~ramWEN | (ramstore == lat_data);
    assign match     = (state == COUNT) & same_op & same_addr & same_data;
    assign cnt_zero  = (cnt == '0);
    assign access    = ~invalid & req & match & cnt_zero;

    // State register
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_wr   <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            lat_wr   <= lat_wr_n;
            lat_addr <= lat_addr_n;
            lat_data <= lat_data_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        lat_wr_n   = lat_wr;
        lat_addr_n = lat_addr;
        lat_data_n = lat_data;
        if (invalid || !req) begin
            // Dropped or illegal request abandons whatever was in flight.
            state_n    = IDLE;
            cnt_n      = '0;
            lat_wr_n   = 1'b0;
            lat_addr_n = '0;
            lat_data_n = '0;
        end else if (!match) begin
            // Fresh request, or the held one changed under us: start over.
            state_n    = COUNT;
            cnt_n      = RELOAD;
            lat_wr_n   = ramWEN;
            lat_addr_n = ramaddr;
            lat_data_n = ramstore;
        end else if (cnt_zero) begin
            // ACCESS cycle; a request still held afterwards is a new transaction.
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            cnt_n = cnt - 1'b1;
        end
    end

    // Output logic
    always_comb begin
        ramstate = BUSY;
        ramload  = '0;
        arr_we   = 1'b0;
        if (invalid) begin
            ramstate = ERROR;
        end else if (!req) begin
            ramstate = FREE;
        end else if (access) begin
            ramstate = ACCESS;
            arr_we   = lat_wr;
            if (!lat_wr) begin
                ramload = arr_rdata;
            end
        end
    end

    ram_array #(
        .AW (AW)
    ) u_array (
        .CLK   (CLK),
        .we    (arr_we),
        .waddr (lat_addr[AW+1:2]),
        .wdata (lat_data),
        .raddr (lat_addr[AW+1:2]),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_ram_sequencer.sv
// Bench for ram_sequencer: two instances (LAT=2 and LAT=1) share one stimulus stream.
// A cycle-level transaction model (age since first seen, word map) predicts both every cycle.
// Directed sequences pin the model with literal expectations, then a random phase follows.
module tb_ram_sequencer;
    import cpu_types_pkg::*;

    logic      CLK;
    logic      nRST;
    logic      ramREN, ramWEN;
    word_t     ramaddr, ramstore;
    word_t     ld2, ld1;
    ramstate_t st2, st1;

    int pass_cnt;
    int total_cnt;
    bit chk_on;

    ram_sequencer #(.LAT(2), .AW(14)) u_lat2 (
        .CLK(CLK), .nRST(nRST), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ld2), .ramstate(st2)
    );

    ram_sequencer #(.LAT(1), .AW(14)) u_lat1 (
        .CLK(CLK), .nRST(nRST), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ld1), .ramstate(st1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    bit          tx_v  [2];
    logic        tx_wr [2];
    logic [29:0] tx_a  [2];
    word_t       tx_d  [2];
    int          age   [2];
    word_t       mem   [int];   // key = instance*65536 + word index

    task automatic model_step(input int i, output ramstate_t es, output word_t el, output bit lk);
        int  lat;
        bit  rq, inv, same;
        int  key;
        lat = (i == 0) ? 2 : 1;
        rq  = ramREN ^ ramWEN;
        inv = (ramREN && ramWEN) || (ramaddr[31:16] != 16'h0);
`ifdef RAM_ALIGN_CHECK_EN
        if (rq && ramaddr[1:0] != 2'b00) inv = 1'b1;
`endif
        key = i * 65536 + int'(ramaddr[15:2]);
        el  = 32'h0;
        lk  = 1'b1;
        if (!nRST) begin
            tx_v[i] = 1'b0;
            es = inv ? ERROR : (rq ? BUSY : FREE);
        end else if (inv) begin
            tx_v[i] = 1'b0;
            es = ERROR;
        end else if (!rq) begin
            tx_v[i] = 1'b0;
            es = FREE;
        end else begin
            same = tx_v[i] && (tx_wr[i] == ramWEN) && (tx_a[i] == ramaddr[31:2])
                   && (!ramWEN || tx_d[i] == ramstore);
            if (same) begin
                age[i]++;
                if (age[i] == lat) begin
                    es = ACCESS;
                    tx_v[i] = 1'b0;
                    if (ramWEN) mem[key] = ramstore;
                    else if (mem.exists(key)) el = mem[key];
                    else lk = 1'b0;
                end else begin
                    es = BUSY;
                end
            end else begin
                tx_v[i]  = 1'b1;
                tx_wr[i] = ramWEN;
                tx_a[i]  = ramaddr[31:2];
                tx_d[i]  = ramstore;
                age[i]   = 0;
                es = BUSY;
            end
        end
    endtask

    // Compare process: every cycle, both instances, state and read data.
    always @(negedge CLK) begin
        ramstate_t es;
        word_t     el;
        bit        lk;
        if (chk_on) begin
            model_step(0, es, el, lk);
            chk("model_state_lat2", 32'(st2), 32'(es));
            if (lk) chk("model_load_lat2", ld2, el);
            model_step(1, es, el, lk);
            chk("model_state_lat1", 32'(st1), 32'(es));
            if (lk) chk("model_load_lat1", ld1, el);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic r, input logic w, input word_t a, input word_t d, input logic rn);
        @(posedge CLK);
        #1;
        ramREN = r; ramWEN = w; ramaddr = a; ramstore = d; nRST = rn;
        @(negedge CLK);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    initial begin
        logic  r, w, rn;
        word_t a, d;
        int    dur, kind;

        pass_cnt = 0; total_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            tx_v[i] = 1'b0; tx_wr[i] = 1'b0; tx_a[i] = '0; tx_d[i] = '0; age[i] = 0;
        end
        ramREN = 0; ramWEN = 0; ramaddr = 0; ramstore = 0; nRST = 0;
        chk_on = 1'b1;

        // Reset behaviour: FREE / BUSY / ERROR from inputs, load 0.
        cyc(0, 0, 32'h0, 32'h0, 0);
        chk("rst_free", 32'(st2), 32'(FREE));
        chk("rst_load", ld2, 32'h0);
        cyc(1, 0, 32'h40, 32'h0, 0);
        chk("rst_busy", 32'(st2), 32'(BUSY));
        cyc(1, 1, 32'h40, 32'h0, 0);
        chk("rst_error", 32'(st1), 32'(ERROR));
        idle();

        // Write 0x40 <= DEADBEEF, then read it back.
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 32'h40, 32'hDEAD_BEEF, 1);
            chk("wr40_state", 32'(st2), (k < 2) ? 32'(BUSY) : 32'(ACCESS));
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 32'h40, 32'h0, 1);
            chk("rd40_state", 32'(st2), (k < 2) ? 32'(BUSY) : 32'(ACCESS));
            if (k == 1) chk("rd40_lat1_load", ld1, 32'hDEAD_BEEF);
        end
        chk("rd40_load", ld2, 32'hDEAD_BEEF);
        idle();

        // Address changes mid-count: restart, data comes from the new address.
        for (int k = 0; k < 3; k++) cyc(0, 1, 32'h80, 32'hA5A5_0080, 1);
        idle();
        for (int k = 0; k < 3; k++) cyc(0, 1, 32'h84, 32'h5A5A_0084, 1);
        idle();
        cyc(1, 0, 32'h80, 32'h0, 1);
        chk("chg_first", 32'(st2), 32'(BUSY));
        for (int k = 0; k < 3; k++) begin
            cyc(1, 0, 32'h84, 32'h0, 1);
            chk("chg_state", 32'(st2), (k < 2) ? 32'(BUSY) : 32'(ACCESS));
        end
        chk("chg_load", ld2, 32'h5A5A_0084);
        idle();

        // Read+write together is an error and writes nothing.
        for (int k = 0; k < 3; k++) cyc(0, 1, 32'h10, 32'h0000_1010, 1);
        idle();
        cyc(1, 1, 32'h10, 32'hFFFF_FFFF, 1);
        chk("both_error", 32'(st2), 32'(ERROR));
        chk("both_load", ld2, 32'h0);
        for (int k = 0; k < 3; k++) cyc(1, 0, 32'h10, 32'h0, 1);
        chk("both_reread", ld2, 32'h0000_1010);
        idle();

        // Out-of-range and misaligned addresses.
        cyc(1, 0, 32'h0010_0000, 32'h0, 1);
        chk("range_error", 32'(st2), 32'(ERROR));
        idle();
        for (int k = 0; k < 3; k++) cyc(1, 0, 32'h42, 32'h0, 1);
`ifdef RAM_ALIGN_CHECK_EN
        chk("align_state", 32'(st2), 32'(ERROR));
        chk("align_load", ld2, 32'h0);
`else
        chk("align_state", 32'(st2), 32'(ACCESS));
        chk("align_load", ld2, 32'hDEAD_BEEF);
`endif
        idle();

        // Reset mid-write discards the write.
        for (int k = 0; k < 3; k++) cyc(0, 1, 32'h20, 32'hCAFE_0020, 1);
        idle();
        cyc(0, 1, 32'h20, 32'h1234_5678, 1);
        cyc(0, 1, 32'h20, 32'h1234_5678, 0);
        chk("rstwr_state", 32'(st1), 32'(BUSY));
        idle();
        for (int k = 0; k < 3; k++) cyc(1, 0, 32'h20, 32'h0, 1);
        chk("rstwr_reread", ld2, 32'hCAFE_0020);
        idle();

        // LAT=1 write held past ACCESS: BUSY ACCESS BUSY ACCESS BUSY.
        for (int k = 0; k < 5; k++) begin
            cyc(0, 1, 32'h30, 32'h0BAD_F00D, 1);
            chk("hold_lat1", 32'(st1), (k % 2 == 1) ? 32'(ACCESS) : 32'(BUSY));
        end
        idle();
        cyc(1, 0, 32'h30, 32'h0, 1);
        cyc(1, 0, 32'h30, 32'h0, 1);
        chk("hold_reread", ld1, 32'h0BAD_F00D);
        idle();

        // Random phase.
        for (int t = 0; t < 150; t++) begin
            kind = int'($urandom_range(0, 19));
            r = 1'($urandom_range(0, 1));
            w = ~r;
            if (kind == 0) begin r = 1'b1; w = 1'b1; end
            a = 32'h100 + ($urandom_range(0, 7) << 2);
            if (kind == 1) a = a | 32'h0004_0000;
            if (kind == 2) a = a | 32'($urandom_range(1, 3));
            d = $urandom;
            dur = int'($urandom_range(1, 5));
            for (int k = 0; k < dur; k++) begin
                rn = ($urandom_range(0, 39) != 0);
                if ($urandom_range(0, 7) == 0) d = $urandom;
                if ($urandom_range(0, 11) == 0) a = a ^ 32'h4;
                cyc(r, w, a, d, rn);
            end
            if ($urandom_range(0, 1) == 1) idle();
        end

        chk_on = 1'b0;
        @(posedge CLK);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
